int_key_arb: RTL

INT_KEY_ARB -- requirements
Module: int_key_arb

---
 rtl/int_key_pkg.sv | 18 +
 rtl/int_key_chan.sv | 50 +++++
 rtl/int_key_arb.sv | 89 ++++++++
 3 files changed

// File: rtl/int_key_pkg.sv
// Shared types and constants for the key-press interrupt arbiter.
package int_key_pkg;

    localparam int unsigned PULSE_LEN_DEFAULT = 6;
    localparam int unsigned CNT_W             = 8;

    typedef enum logic {
        CH_IDLE = 1'b0,
        CH_HELD = 1'b1
    } ch_state_e;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_PULSE = 2'd1,
        ARB_GAP   = 2'd2
    } arb_state_e;

endpackage

// File: rtl/int_key_chan.sv
// One key channel: edge-detecting press FSM plus the latched pending request bit.
module int_key_chan
    import int_key_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic press,
    input  logic en,
    input  logic clr,
    output logic pending
);

    ch_state_e state_q;
    ch_state_e state_d;
    logic      pending_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= CH_IDLE;
            pending <= 1'b0;
        end else begin
            state_q <= state_d;
            pending <= pending_d;
        end
    end

    // A new press sets pending after the arbiter clear, so set wins a same-edge collision.
    always_comb begin
        state_d   = state_q;
        pending_d = pending & ~clr;
        case (state_q)
            CH_IDLE: begin
                if (press) begin
                    state_d   = CH_HELD;
                    pending_d = 1'b1;
                end
            end
            CH_HELD: begin
                if (!press) begin
                    state_d = CH_IDLE;
                end
            end
            default: state_d = CH_IDLE;
        endcase
        if (!en) begin
            pending_d = 1'b0;
        end
    end

endmodule

// File: rtl/int_key_arb.sv
// Key interrupt arbiter: serves pending channels lowest-index first, one fixed-length
// interrupt pulse per request, with a single low cycle between pulses.
module int_key_arb
    import int_key_pkg::*;
#(
    parameter int unsigned NUM_CH    = 4,
    parameter int unsigned PULSE_LEN = PULSE_LEN_DEFAULT,
    parameter int unsigned IDW       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] press,
    input  logic [NUM_CH-1:0] int_en,
    output logic              interrupt,
    output logic [IDW-1:0]    int_id,
    output logic [NUM_CH-1:0] pending
);

    arb_state_e        state_q;
    arb_state_e        state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;
    logic [IDW-1:0]    id_d;
    logic [IDW-1:0]    sel;
    logic [NUM_CH-1:0] clr;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
        int_key_chan u_chan (
            .clk     (clk),
            .rst_n   (rst_n),
            .press   (press[g]),
            .en      (int_en[g]),
            .clr     (clr[g]),
            .pending (pending[g])
        );
    end

    // Lowest set pending index.
    always_comb begin
        sel = '0;
        for (int i = int'(NUM_CH) - 1; i >= 0; i--) begin
            if (pending[i]) begin
                sel = IDW'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ARB_IDLE;
            cnt_q     <= '0;
            int_id    <= '0;
            interrupt <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            int_id    <= id_d;
            interrupt <= (state_d == ARB_PULSE);
        end
    end

    // The gap cycle may dispatch the next request itself, so back-to-back pulses
    // are separated by exactly one low cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        id_d    = int_id;
        clr     = '0;
        case (state_q)
            ARB_IDLE, ARB_GAP: begin
                state_d = ARB_IDLE;
                if (|pending) begin
                    state_d = ARB_PULSE;
                    cnt_d   = CNT_W'(PULSE_LEN);
                    id_d    = sel;
                    clr     = NUM_CH'(1) << sel;
                end
            end
            ARB_PULSE: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ARB_GAP;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

endmodule
